// File: rtl/phase_sequencer.sv
// Multi-phase clock sequencer: one-hot phase strobes, divided clock, run/step control,
// stall hold on one phase and a completed-cycle counter. Optional macro: PHASE_SEQ_DUTY50_EN.
module phase_sequencer #(
    parameter int N_PHASES    = 3,
    parameter int STALL_PHASE = 1,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        step_req,
    input  logic                        stall,
    output logic [N_PHASES-1:0]         phase_o,
    output logic [$clog2(N_PHASES)-1:0] phase_idx,
    output logic                        clk_div,
    output logic                        cycle_done,
    output logic                        busy,
    output logic [CNT_W-1:0]            cycle_cnt
);

    localparam int IDX_W = $clog2(N_PHASES);
    localparam logic [IDX_W-1:0]    LAST_IDX      = IDX_W'(N_PHASES - 1);
    localparam logic [IDX_W-1:0]    STALL_IDX     = IDX_W'(STALL_PHASE);
    localparam logic [IDX_W-1:0]    HIGH_IDX      = IDX_W'((N_PHASES + 1) / 2);
    localparam logic [N_PHASES-1:0] FIRST_PHASE   = N_PHASES'(1);
    localparam bit                  STALL_ON_LAST = (STALL_PHASE == N_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N_PHASES-1:0] phase_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic                busy_nxt;
    logic                cnt_inc;
    logic                hold;
    logic                at_last;
    logic                clk_base;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_o;
        idx_nxt   = phase_idx;
        cnt_inc   = 1'b0;
        hold      = (phase_idx == STALL_IDX) && stall;
        at_last   = (phase_idx == LAST_IDX);

        case (state)
            IDLE: begin
                // run wins over a simultaneous step request, which is simply dropped
                if (run) begin
                    state_nxt = RUN;
                    phase_nxt = FIRST_PHASE;
                    idx_nxt   = '0;
                end else if (step_req) begin
                    state_nxt = STEP;
                    phase_nxt = FIRST_PHASE;
                    idx_nxt   = '0;
                end
            end
            RUN, STEP: begin
                if (!hold) begin
                    if (at_last) begin
                        // run is only re-examined at the sequence boundary
                        cnt_inc = 1'b1;
                        idx_nxt = '0;
                        if (run) begin
                            state_nxt = RUN;
                            phase_nxt = FIRST_PHASE;
                        end else begin
                            state_nxt = IDLE;
                            phase_nxt = '0;
                        end
                    end else begin
                        idx_nxt   = phase_idx + IDX_W'(1);
                        phase_nxt = phase_o << 1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                idx_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_o   <= '0;
            phase_idx <= '0;
            busy      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase_o   <= phase_nxt;
            phase_idx <= idx_nxt;
            busy      <= busy_nxt;
            if (cnt_inc) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // a stall on the last phase means this edge will not advance, so no completion
    assign cycle_done = phase_o[N_PHASES-1] & ~(stall & STALL_ON_LAST);
    assign clk_base   = busy & (phase_idx >= HIGH_IDX);

`ifdef PHASE_SEQ_DUTY50_EN
    localparam bit ODD_N = (N_PHASES % 2) == 1;

    logic ext_q;

    // stretches the high level half a clock past the last phase to even out odd-N duty
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= busy & (phase_idx == LAST_IDX);
        end
    end

    assign clk_div = clk_base | (ext_q & ODD_N);
`else
    assign clk_div = clk_base;
`endif

endmodule
